// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the datapath ALU.
// Walks an external combinational vector ROM, drives each vector into the
// ALU through registers, checks the ALU response one cycle later and reports
// an error count, the first failing index and done/pass.
module alu_bist #(
  parameter int N    = 64,
  parameter int NVEC = 15,
  parameter int IW   = (NVEC > 1) ? $clog2(NVEC) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [IW-1:0] vec_idx,
  input  logic [N-1:0]  vec_a,
  input  logic [N-1:0]  vec_b,
  input  logic [N-1:0]  vec_y,
  input  logic [3:0]    vec_ctl,
  input  logic          vec_zero,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_ctl,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_zero,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_cnt,
  output logic          fail_valid,
  output logic [IW-1:0] fail_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NVEC - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] vec_idx_q, vec_idx_d;
  logic [N-1:0]  alu_a_q, alu_a_d;
  logic [N-1:0]  alu_b_q, alu_b_d;
  logic [3:0]    alu_ctl_q, alu_ctl_d;
  logic [N-1:0]  exp_y_q, exp_y_d;
  logic          exp_zero_q, exp_zero_d;
  logic          chk_valid_q, chk_valid_d;
  logic [IW-1:0] chk_idx_q, chk_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          fail_valid_q, fail_valid_d;
  logic [IW-1:0] fail_idx_q, fail_idx_d;
  logic          mismatch;

  // Next-state: vector issue, response check and run bookkeeping.
  // The check of the previously issued vector is evaluated first; an accepted
  // start then overrides the counters (no check is ever pending in IDLE/DONE).
  always_comb begin
    state_d      = state_q;
    vec_idx_d    = vec_idx_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctl_d    = alu_ctl_q;
    exp_y_d      = exp_y_q;
    exp_zero_d   = exp_zero_q;
    chk_valid_d  = chk_valid_q;
    chk_idx_d    = chk_idx_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;

    mismatch = chk_valid_q &&
               ((alu_result != exp_y_q) || (alu_zero != exp_zero_q));

    if (mismatch) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_idx_d   = chk_idx_q;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          vec_idx_d    = '0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_idx_d   = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      ST_RUN: begin
        alu_a_d     = vec_a;
        alu_b_d     = vec_b;
        alu_ctl_d   = vec_ctl;
        exp_y_d     = vec_y;
        exp_zero_d  = vec_zero;
        chk_valid_d = 1'b1;
        chk_idx_d   = vec_idx_q;
        if (vec_idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          vec_idx_d = vec_idx_q + IW'(1);
        end
      end
      ST_DRAIN: begin
        chk_valid_d = 1'b0;
        state_d     = ST_DONE;
        done_d      = 1'b1;
        pass_d      = (err_cnt_d == '0);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      vec_idx_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctl_q    <= '0;
      exp_y_q      <= '0;
      exp_zero_q   <= 1'b0;
      chk_valid_q  <= 1'b0;
      chk_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctl_q    <= alu_ctl_d;
      exp_y_q      <= exp_y_d;
      exp_zero_q   <= exp_zero_d;
      chk_valid_q  <= chk_valid_d;
      chk_idx_q    <= chk_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  assign vec_idx    = vec_idx_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctl    = alu_ctl_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: golden ALU with selectable faults and a
// 15-vector ROM on one instance, an always-wrong ALU on a 255-vector instance.
module tb_alu_bist;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  int   fault = 0;    // 0 none, 1 result bit16 forced 0, 2 zero stuck at 0
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // ---------------- instance 1: NVEC=15 ----------------
  logic [3:0]  vec_idx, fail_idx;
  logic [63:0] vec_a, vec_b, vec_y, alu_a, alu_b, alu_result;
  logic [3:0]  vec_ctl, alu_ctl;
  logic        vec_zero, alu_zero, busy, done, pass, fail_valid;
  logic [7:0]  err_cnt;

  localparam logic [63:0] ROM_A [15] = '{
    64'h267B, 64'h1234, 64'h6D55, 64'h1000, 64'h5A5A, 64'h4589, 64'hABCD, 64'hFFFF,
    64'h0000, 64'h1111, 64'h2222, 64'h0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hF0F0, 64'h7777};
  localparam logic [63:0] ROM_B [15] = '{
    64'h03D8, 64'h0F0F, 64'h92AA, 64'h0234, 64'h5A5A, 64'h32A2, 64'hB34F, 64'hFFFF,
    64'h0000, 64'h42A4, 64'h0000, 64'h0001, 64'h0001, 64'h0FF0, 64'h7777};
  localparam logic [3:0] ROM_C [15] = '{
    4'h0, 4'h1, 4'h0, 4'h2, 4'h6, 4'h6, 4'h2, 4'h2,
    4'h1, 4'h7, 4'h7, 4'h6, 4'h2, 4'h0, 4'h6};
  localparam logic [63:0] ROM_Y [15] = '{
    64'h0258, 64'h1F3F, 64'h0, 64'h1234, 64'h0, 64'h12E7, 64'h15F1C, 64'h1FFFE,
    64'h0, 64'h42A4, 64'h0, 64'h00FF, 64'h0, 64'h00F0, 64'h0};
  localparam logic ROM_Z [15] = '{
    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  assign vec_a    = ROM_A[vec_idx];
  assign vec_b    = ROM_B[vec_idx];
  assign vec_ctl  = ROM_C[vec_idx];
  assign vec_y    = ROM_Y[vec_idx];
  assign vec_zero = ROM_Z[vec_idx];

  // golden ALU with planted faults
  logic [63:0] gold;
  always_comb begin
    gold = '0;
    case (alu_ctl)
      4'h0: gold = alu_a & alu_b;
      4'h1: gold = alu_a | alu_b;
      4'h2: gold = alu_a + alu_b;
      4'h6: gold = alu_a - alu_b;
      4'h7: gold = alu_b;
      default: gold = '0;
    endcase
    if (fault == 1) gold[16] = 1'b0;
    alu_result = gold;
    alu_zero   = (fault == 2) ? 1'b0 : (gold == '0);
  end

  alu_bist #(.N(64), .NVEC(15)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_idx(vec_idx),
    .vec_a(vec_a), .vec_b(vec_b), .vec_y(vec_y), .vec_ctl(vec_ctl), .vec_zero(vec_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_idx(fail_idx));

  // ---------------- instance 2: NVEC=255, always-wrong ALU ----------------
  logic [7:0]  vec_idx2, fail_idx2, err_cnt2;
  logic [63:0] alu_a2, alu_b2, alu_result2;
  logic [3:0]  alu_ctl2;
  logic        alu_zero2, busy2, done2, pass2, fail_valid2;

  assign alu_result2 = alu_b2;            // ROM expects 1, ALU returns 0
  assign alu_zero2   = (alu_result2 == '0);

  alu_bist #(.N(64), .NVEC(255)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .vec_idx(vec_idx2),
    .vec_a({56'd0, vec_idx2}), .vec_b(64'd0), .vec_y(64'd1), .vec_ctl(4'h7), .vec_zero(1'b0),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_ctl(alu_ctl2),
    .alu_result(alu_result2), .alu_zero(alu_zero2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .fail_valid(fail_valid2), .fail_idx(fail_idx2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pulse start so that exactly one edge samples it; returns #1 after that edge
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // from #1 after the start edge, step until done; count busy cycles
  task automatic run_to_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 60) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  int cyc, bcnt;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec_idx", 64'(vec_idx), 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_ctl", 64'(alu_ctl), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_pass", 64'(pass), 0);
    check("rst_err_cnt", 64'(err_cnt), 0);
    check("rst_fail_valid", 64'(fail_valid), 0);
    check("rst_fail_idx", 64'(fail_idx), 0);
    @(negedge clk);
    reset = 1'b0;

    // golden run
    do_start();
    check("g_busy_first", 64'(busy), 1);
    run_to_done(cyc, bcnt);
    check("g_busy_cycles", 64'(bcnt), 16);
    check("g_done_edge", 64'(cyc), 16);
    check("g_pass", 64'(pass), 1);
    check("g_err_cnt", 64'(err_cnt), 0);
    check("g_fail_valid", 64'(fail_valid), 0);
    check("g_busy_end", 64'(busy), 0);
    check("g_hold_alu_b", alu_b, 64'h7777);
    check("g_hold_alu_ctl", 64'(alu_ctl), 6);
    repeat (2) @(posedge clk);
    #1;
    check("g_done_held", 64'(done), 1);

    // start re-pulsed at cycles 3 and 10 of a run is ignored
    do_start();
    for (int k = 1; k <= 16; k++) begin
      start = (k == 3 || k == 10);
      @(posedge clk);
      #1;
      if (k == 15) check("rp_not_done_15", 64'(done), 0);
    end
    start = 1'b0;
    check("rp_done_16", 64'(done), 1);
    check("rp_pass", 64'(pass), 1);
    check("rp_err_cnt", 64'(err_cnt), 0);

    // result bit 16 stuck at 0
    fault = 1;
    do_start();
    run_to_done(cyc, bcnt);
    check("b16_done_edge", 64'(cyc), 16);
    check("b16_err_cnt", 64'(err_cnt), 2);
    check("b16_fail_valid", 64'(fail_valid), 1);
    check("b16_fail_idx", 64'(fail_idx), 6);
    check("b16_pass", 64'(pass), 0);

    // start from DONE clears results; zero flag stuck at 0
    fault = 2;
    do_start();
    check("rs_done_clr", 64'(done), 0);
    check("rs_err_clr", 64'(err_cnt), 0);
    check("rs_fv_clr", 64'(fail_valid), 0);
    check("rs_fidx_clr", 64'(fail_idx), 0);
    check("rs_busy", 64'(busy), 1);
    run_to_done(cyc, bcnt);
    check("z0_err_cnt", 64'(err_cnt), 6);
    check("z0_fail_idx", 64'(fail_idx), 2);
    check("z0_pass", 64'(pass), 0);

    // reset mid-run at cycle 5 (zero fault so err_cnt is already nonzero)
    do_start();
    repeat (4) @(posedge clk);
    #1;
    check("mr_err_before", 64'(err_cnt), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mr_vec_idx", 64'(vec_idx), 0);
    check("mr_alu_a", alu_a, 0);
    check("mr_alu_b", alu_b, 0);
    check("mr_alu_ctl", 64'(alu_ctl), 0);
    check("mr_busy", 64'(busy), 0);
    check("mr_done", 64'(done), 0);
    check("mr_err_cnt", 64'(err_cnt), 0);
    check("mr_fail_valid", 64'(fail_valid), 0);
    check("mr_fail_idx", 64'(fail_idx), 0);
    reset = 1'b0;
    fault = 0;
    repeat (2) @(posedge clk);
    #1;
    check("mr_idle_busy", 64'(busy), 0);
    do_start();
    run_to_done(cyc, bcnt);
    check("mr2_done_edge", 64'(cyc), 16);
    check("mr2_pass", 64'(pass), 1);
    check("mr2_err_cnt", 64'(err_cnt), 0);

    // NVEC=255, every vector wrong
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("w_done_edge", 64'(cyc), 256);
    check("w_err_cnt", 64'(err_cnt2), 255);
    check("w_fail_valid", 64'(fail_valid2), 1);
    check("w_fail_idx", 64'(fail_idx2), 0);
    check("w_pass", 64'(pass2), 0);
    check("w_vec_idx", 64'(vec_idx2), 254);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Synthesizable built-in self-test sequencer for the datapath ALU (AND/OR/ADD/SUB/pass-B, aluControl 0x0/0x1/0x2/0x6/0x7).
- On `start`, walks an external combinational vector ROM and drives each vector's operands and control into the ALU.
- Samples the ALU result and zero flag one cycle later and compares them against the expected values.
- Reports an error count, the first failing index, and `done`/`pass`.
- Sits beside the ALU; used for power-on and FPGA self-check.

Parameters:
- N, 64, ALU operand and result width.
- NVEC, 15, number of vectors in the ROM (valid range 1..255).
- IW, $clog2(NVEC) (1 when NVEC=1), width of vector index.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a test run; honoured only in IDLE or DONE.
- vec_idx  out  IW  ROM address.
- vec_a  in  N  ROM operand a at vec_idx.
- vec_b  in  N  ROM operand b.
- vec_y  in  N  ROM expected result.
- vec_ctl  in  4  ROM aluControl.
- vec_zero  in  1  ROM expected zero flag.
- alu_a  out  N  registered ALU operand a.
- alu_b  out  N  registered ALU operand b.
- alu_ctl  out  4  registered ALU control.
- alu_result  in  N  ALU result (combinational from alu_a/alu_b/alu_ctl).
- alu_zero  in  1  ALU zero flag.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  run finished; held until next accepted start or reset.
- pass  out  1  done && err_cnt==0.
- err_cnt  out  8  failing-vector count, saturates at 255.
- fail_valid  out  1  at least one failure seen in this run.
- fail_idx  out  IW  index of first failing vector.

Behaviour:
- Reset (sync, active-high; overrides everything, including mid-run):
  - state=IDLE.
  - All outputs 0: vec_idx, alu_a, alu_b, alu_ctl, busy, done, pass, err_cnt, fail_valid, fail_idx.
  - Internal exp_y, exp_zero, chk_valid = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start at edge E0:
  - state->RUN, vec_idx<=0, err_cnt<=0, fail_valid<=0, fail_idx<=0, done<=0.
- RUN, each edge:
  - alu_a<=vec_a, alu_b<=vec_b, alu_ctl<=vec_ctl.
  - exp_y<=vec_y, exp_zero<=vec_zero, chk_valid<=1.
  - If vec_idx==NVEC-1: state->DRAIN, vec_idx holds. Otherwise vec_idx<=vec_idx+1.
- Compare, at every edge where chk_valid==1 (RUN or DRAIN):
  - Mismatch = (alu_result!=exp_y) || (alu_zero!=exp_zero).
  - Each mismatching vector increments err_cnt once (both fields wrong still counts 1), saturating at 255.
  - First mismatch sets fail_valid<=1 and fail_idx<=index of the vector being checked. Later mismatches do not change fail_idx.
- DRAIN, one edge:
  - Compares the last vector; chk_valid<=0; state->DONE; done<=1.
- Timing:
  - Vector k is issued at edge E(k+1) and checked at edge E(k+2).
  - done is first high after edge E(NVEC+1). Total latency is NVEC+1 cycles from the start-sampling edge.
- start while busy is ignored: no restart, no counter clear.
- start held high continuously in DONE begins a new run each time DONE is reached.
- alu_a/alu_b/alu_ctl hold their last vector in DRAIN, DONE and IDLE (after reset they are 0).
- busy = (state==RUN || state==DRAIN). pass is registered with done. pass=0 whenever done=0.
- NVEC=1: RUN lasts one edge, then DRAIN.
- Equality is over all N bits. No masking.
- Subtraction result is two's complement, so expected 0x569B-0xB858 = 0xFFFFFFFFFFFF9E43.

Test Plan:
- Golden ALU + 15-vector ROM (e.g. 0x267B AND 0x3D8=0x258 z0; 0x6D55 AND 0x92AA=0 z1; 0xFFFF+0xFFFF=0x1FFFE; 0x4589-0x32A2=0x12E7; pass-B 0x42A4) -> busy high for 16 cycles, done after edge 16, pass=1, err_cnt=0, fail_valid=0.
- ALU fault model forcing result bit 16 to 0 -> only vector 0xFFFF+0xFFFF (index 7) and 0x15F1C ADD (index 6) fail -> err_cnt=2, fail_idx=6, pass=0.
- Zero flag stuck at 0 -> vectors with expected zero=1 (indices 2,4,8,10,12,14) fail -> err_cnt=6, fail_idx=2.
- Reset asserted at cycle 5 of a run -> all outputs 0 next edge, state IDLE. New start then completes cleanly with pass=1.
- start re-pulsed at cycles 3 and 10 of a run -> ignored; done still after edge 16. A start while in DONE clears err_cnt/done and reruns.
- Always-wrong ALU with NVEC=255 ROM -> err_cnt=255 at done (no wrap), fail_idx=0.
